// File: rtl/capi_command_issue_if.sv
// PSL command/response types and the engine request handshake interface.
// The interface carries one request per req_valid & req_ready cycle.
package capi_pkg;

  typedef enum logic [12:0] {
    READ_CL_NA = 13'h0A80,
    READ_CL_S  = 13'h0A50,
    WRITE_NA   = 13'h0D00,
    WRITE_MI   = 13'h0D60
  } afu_command_t;

  typedef struct packed {
    logic [7:0] room;
  } CommandInterfaceInput;

  typedef struct packed {
    logic       valid;
    logic [7:0] tag;
    logic       tag_parity;
    logic [7:0] response;
    logic [8:0] credits;
  } ResponseInterface;

  typedef struct packed {
    logic        valid;
    logic [7:0]  tag;
    logic        tag_parity;
    logic [12:0] command;
    logic        command_parity;
    logic [2:0]  abt;
    logic [63:0] address;
    logic        address_parity;
    logic [15:0] context_handle;
    logic [11:0] size;
  } CommandInterfaceOutput;

  localparam logic [7:0] RESP_DONE = 8'h00;

endpackage

interface capi_command_issue_if;
  import capi_pkg::*;

  logic         req_valid;
  afu_command_t req_command;
  logic [2:0]   req_abt;
  logic [63:0]  req_address;
  logic [11:0]  req_size;
  logic         req_ready;
  logic [7:0]   req_tag;

  modport master (
    output req_valid, req_command, req_abt, req_address, req_size,
    input  req_ready, req_tag
  );

  modport slave (
    input  req_valid, req_command, req_abt, req_address, req_size,
    output req_ready, req_tag
  );

endinterface

// File: rtl/capi_command_issue.sv
// Tags and credit-gates engine requests onto the PSL command bus, 1 cycle accept->command_out; req_ready low
// outside RUN or with no credit/free tag. Optional macro RESP_PARITY_CHECK_EN checks response tag parity.
module capi_command_issue
  import capi_pkg::*;
#(
  parameter int NUM_TAGS     = 32,
  parameter int CREDIT_WIDTH = 9
) (
  input  logic                         clock,
  input  logic                         rstn,
  input  logic                         job_start,
  input  logic                         job_stop,
  input  CommandInterfaceInput         command_in,
  input  logic [15:0]                  context_handle,
  capi_command_issue_if.slave          req,
  input  ResponseInterface             response_in,
  output CommandInterfaceOutput        command_out,
  output logic [CREDIT_WIDTH-1:0]      credits,
  output logic [$clog2(NUM_TAGS):0]    outstanding,
  output logic                         resp_error,
  output logic [7:0]                   error_tag,
  output logic                         drained
);

  localparam int TW = $clog2(NUM_TAGS);
  localparam int OW = TW + 1;
  localparam int SW = ((CREDIT_WIDTH > 9) ? CREDIT_WIDTH : 9) + 2;
  localparam logic signed [SW-1:0] CRED_MAX = {{(SW-CREDIT_WIDTH){1'b0}}, {CREDIT_WIDTH{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
  logic [OW-1:0]           outstanding_q, outstanding_d;
  logic [NUM_TAGS-1:0]     free_q, free_d;
  logic                    resp_error_q, resp_error_d;
  logic [7:0]              error_tag_q, error_tag_d;
  logic                    drained_q, drained_d;
  CommandInterfaceOutput   cmd_q, cmd_d;

  logic [TW-1:0]           alloc_idx;
  logic                    any_free;
  logic                    ready;
  logic                    accept;
  logic [TW-1:0]           rsp_idx;
  logic                    rsp_in_range;
  logic                    rsp_busy;
  logic                    rsp_par_bad;
  logic                    rsp_take;
  logic                    rsp_err_evt;
  logic signed [SW-1:0]    cred_cur;
  logic signed [SW-1:0]    cred_rsp;
  logic signed [SW-1:0]    cred_sum;

  // Downward scan so the last hit is the lowest free tag.
  always_comb begin
    alloc_idx = '0;
    any_free  = 1'b0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (free_q[i]) begin
        alloc_idx = TW'(i);
        any_free  = 1'b1;
      end
    end
  end

  assign ready         = (state_q == RUN) && (credits_q != '0) && any_free;
  assign accept        = req.req_valid & ready;
  assign req.req_ready = ready;
  assign req.req_tag   = 8'(alloc_idx);

  assign rsp_idx      = response_in.tag[TW-1:0];
  assign rsp_in_range = (response_in.tag >> TW) == 8'd0;
  assign rsp_busy     = rsp_in_range & ~free_q[rsp_idx];

`ifdef RESP_PARITY_CHECK_EN
  assign rsp_par_bad = response_in.tag_parity != ~^response_in.tag;
`else
  logic unused_tag_parity;
  assign unused_tag_parity = response_in.tag_parity;
  assign rsp_par_bad       = 1'b0;
`endif

  // A response for an idle tag, a bad parity or a non-DONE code is an error; only the first two are dropped.
  assign rsp_take    = response_in.valid & rsp_busy & ~rsp_par_bad;
  assign rsp_err_evt = response_in.valid &
                       (rsp_par_bad | ~rsp_busy | (response_in.response != RESP_DONE));

  always_comb begin
    cred_cur = {{(SW-CREDIT_WIDTH){1'b0}}, credits_q};
    cred_rsp = '0;
    if (rsp_take) begin
      cred_rsp = {{(SW-9){response_in.credits[8]}}, response_in.credits};
    end
    cred_sum = cred_cur + cred_rsp;
    if (accept) begin
      cred_sum = cred_sum - SW'(1);
    end
  end

  always_comb begin
    credits_d     = credits_q;
    outstanding_d = outstanding_q + OW'(accept) - OW'(rsp_take);
    free_d        = free_q;
    resp_error_d  = resp_error_q | rsp_err_evt;
    error_tag_d   = error_tag_q;
    drained_d     = 1'b0;
    state_d       = state_q;
    cmd_d         = cmd_q;
    cmd_d.valid   = accept;

    if (cred_sum < 0) begin
      credits_d = '0;
    end else if (cred_sum > CRED_MAX) begin
      credits_d = CRED_MAX[CREDIT_WIDTH-1:0];
    end else begin
      credits_d = cred_sum[CREDIT_WIDTH-1:0];
    end

    if (accept) begin
      free_d[alloc_idx]    = 1'b0;
      cmd_d.tag            = 8'(alloc_idx);
      cmd_d.tag_parity     = ~^(8'(alloc_idx));
      cmd_d.command        = req.req_command;
      cmd_d.command_parity = ~^req.req_command;
      cmd_d.abt            = req.req_abt;
      cmd_d.address        = req.req_address;
      cmd_d.address_parity = ~^req.req_address;
      cmd_d.context_handle = context_handle;
      cmd_d.size           = req.req_size;
    end
    if (rsp_take) begin
      free_d[rsp_idx] = 1'b1;
    end
    if (rsp_err_evt && !resp_error_q) begin
      error_tag_d = response_in.tag;
    end

    case (state_q)
      IDLE: begin
        if (job_start) begin
          credits_d = CREDIT_WIDTH'(command_in.room);
          state_d   = RUN;
        end
      end
      RUN: begin
        if (job_stop) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding_d == '0) begin
          drained_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      credits_q     <= '0;
      outstanding_q <= '0;
      free_q        <= '1;
      resp_error_q  <= 1'b0;
      error_tag_q   <= 8'h00;
      drained_q     <= 1'b0;
      cmd_q         <= '0;
    end else begin
      state_q       <= state_d;
      credits_q     <= credits_d;
      outstanding_q <= outstanding_d;
      free_q        <= free_d;
      resp_error_q  <= resp_error_d;
      error_tag_q   <= error_tag_d;
      drained_q     <= drained_d;
      cmd_q         <= cmd_d;
    end
  end

  assign command_out = cmd_q;
  assign credits     = credits_q;
  assign outstanding = outstanding_q;
  assign resp_error  = resp_error_q;
  assign error_tag   = error_tag_q;
  assign drained     = drained_q;

endmodule

// File: doc/capi_command_issue.md
Name: capi_command_issue

Overview:
- Upstream feeder of the PSL command interface. Accepts AFU engine requests, allocates a free tag, debits a command credit, and drives a registered CommandInterfaceOutput.
- Retires tags and restores credits from ResponseInterface.
- Sits between the AFU compute engines and the top-level CAPI wrapper.

Parameters:
NUM_TAGS, 32, outstanding command tags in use; must be a power of 2 and at most 256
CREDIT_WIDTH, 9, width of credit counter (holds 0..room)

Ports:
clock  input  1  PSL clock (ha_pclock domain)
rstn  input  1  asynchronous active-low reset
job_start  input  1  one-cycle pulse: job START received; loads credits
job_stop  input  1  one-cycle pulse: stop issuing, drain outstanding
command_in  input  CommandInterfaceInput  ha_croom; sampled on job_start
context_handle  input  16  copied to command_out.context_handle
req_valid  input  1  engine request valid
req_command  input  afu_command_t  command code
req_abt  input  3  ABT
req_address  input  64  effective address
req_size  input  12  transfer size in bytes
req_ready  output  1  request accepted when req_valid & req_ready
req_tag  output  8  tag assigned to the accepted request (valid with handshake)
response_in  input  ResponseInterface  PSL response
command_out  output  CommandInterfaceOutput  to PSL
credits  output  CREDIT_WIDTH  current available credits
outstanding  output  log2(NUM_TAGS)+1  tags in flight
resp_error  output  1  sticky: non-DONE response seen
error_tag  output  8  tag of first failing response
drained  output  1  one-cycle pulse on DRAIN -> IDLE

Behaviour:
- Reset (async, rstn=0): state IDLE; command_out all zero; req_ready=0; credits=0; outstanding=0; free bitmap all 1; resp_error=0; error_tag=0; drained=0.
- FSM states:
  - IDLE: req_ready=0. On job_start: credits <= room (zero-extended); go to RUN.
  - RUN: on job_stop, go to DRAIN. A job_stop coinciding with an accept still issues that command.
  - DRAIN: no new accepts. When outstanding==0, pulse drained and go to IDLE.
  - job_start in RUN or DRAIN is ignored.
- req_ready = (state==RUN) & (credits!=0) & (any free tag). Combinational from registered state only; does not depend on req_valid.
- Tag allocation: lowest-numbered free tag (priority encoder). req_tag carries it in the accept cycle.
- Issue latency: on accept in cycle N, command_out is presented in cycle N+1:
  - valid=1, with tag, command, abt, address, size and context_handle.
  - tag_parity, command_parity and address_parity are odd parity over their fields.
  - command_out.valid is held for exactly one cycle. Other fields hold their last value.
  - Back-to-back accepts give back-to-back valids.
- Accept: credits -1; outstanding +1; tag marked busy.
- Response (response_in.valid):
  - Frees the tag in response_in.tag.
  - outstanding -1.
  - credits += response_in.credits, treated as signed 9-bit.
- Same cycle accept + response: net update in one cycle. Credits = credits - 1 + rcredits; outstanding unchanged.
  - A tag freed this cycle is not reallocated until the next cycle.
- Response code 0x00 (DONE): normal. Any other code:
  - Sets resp_error.
  - Captures error_tag only if resp_error was 0.
  - The tag is still freed.
- Response for a tag that is already free: ignored; no count or credit change; resp_error is set.
- Credits saturate at 2^CREDIT_WIDTH-1 and never go below 0.
- req_* are unused when not accepted.
- Reset mid-operation: all state cleared immediately; in-flight tags are forgotten.

Optional Feature:
RESP_PARITY_CHECK_EN
- With: response_in.tag_parity is checked as odd parity over response_in.tag on every valid response.
  - On mismatch: set resp_error, capture error_tag per the first-error rule, and discard the response (no tag free, no credit change).
- Without: tag_parity is ignored and every valid response is processed.

Test Plan:
- Reset, job_start with room=4, req_valid held 6 cycles -> exactly 4 accepts, tags 0,1,2,3; command_out.valid in cycles 1-4 after the first accept; credits=0; req_ready=0.
- From the previous state, response tag=2 code 0x00 credits=1 -> credits=1, outstanding=3; next accept reuses tag 2.
- Accept and response (tag 0, credits 1) in the same cycle with credits=1 -> credits stays 1, outstanding unchanged, new tag is not 0.
- Response code 0x01 on tag 1, then code 0x05 on tag 3 -> resp_error=1, error_tag=1.
- job_stop with outstanding=2, then two DONE responses -> no accepts after the stop; drained pulses the cycle after the second response; state returns to IDLE.
- Parity: address 0x0000_0000_0000_0001, command READ_CL_NA -> address_parity=0, command_parity=0. With RESP_PARITY_CHECK_EN, a response with a bad tag_parity -> outstanding unchanged, resp_error=1.
